// File: rtl/ripple_counter.sv
// ripple_counter: WIDTH-bit sync up/down counter built from toggle cells on a rippled carry/borrow chain; ports clk, rstn (active-high sync reset), en, up, ld, din, out, tc, plus sticky ovf when RIPPLE_COUNTER_OVF_STICKY_EN is defined
module ripple_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
`ifdef RIPPLE_COUNTER_OVF_STICKY_EN
  output logic             ovf,
`endif
  output logic             tc
);
  logic [WIDTH-1:0] t;
  assign t[0] = en;
  for (genvar i = 1; i < WIDTH; i++) begin : g_t
    assign t[i] = t[i-1] & (up ? out[i-1] : ~out[i-1]);
  end
  assign tc = ~rstn & ~ld & t[WIDTH-1] & (up ? out[WIDTH-1] : ~out[WIDTH-1]);
  always_ff @(posedge clk)
    out <= rstn ? '0 : ld ? din : out ^ t;
`ifdef RIPPLE_COUNTER_OVF_STICKY_EN
  always_ff @(posedge clk)
    ovf <= ~rstn & ~ld & (ovf | tc);
`endif
endmodule

// File: tb/tb_ripple_counter.sv
// tb_ripple_counter: table-driven and scoreboard check of ripple_counter at WIDTH=4
module tb_ripple_counter;
  logic clk = 1'b0;
  logic rstn, en, up, ld, tc;
  logic [3:0] din, out;
  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];
  logic [3:0] m;
`ifdef RIPPLE_COUNTER_OVF_STICKY_EN
  logic ovf;
  logic mo = 1'b0;
  logic oq[$];
`endif
  typedef struct {
    logic r, e, u, l;
    logic [3:0] d;
    logic [3:0] eo;
    logic et;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ripple_counter #(.WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .ld(ld), .din(din), .out(out),
`ifdef RIPPLE_COUNTER_OVF_STICKY_EN
    .ovf(ovf),
`endif
    .tc(tc)
  );

  task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic r, e, u, l, input logic [3:0] d, eo, input logic et);
    @(negedge clk);
    rstn = r; en = e; up = u; ld = l; din = d;
    #1;
    chk("tc", {3'b0, tc}, {3'b0, et});
    q.push_back(eo);
`ifdef RIPPLE_COUNTER_OVF_STICKY_EN
    mo = r ? 1'b0 : l ? 1'b0 : (mo | et);
    oq.push_back(mo);
`endif
    @(posedge clk);
    #1;
    if (q.size() == 0) chk("queue", 4'd1, 4'd0);
    else chk("out", out, q.pop_front());
`ifdef RIPPLE_COUNTER_OVF_STICKY_EN
    if (oq.size() == 0) chk("oqueue", 4'd1, 4'd0);
    else chk("ovf", {3'b0, ovf}, {3'b0, oq.pop_front()});
`endif
  endtask

  task automatic go(input logic r, e, u, l, input logic [3:0] d);
    logic [3:0] nx;
    logic et;
    nx = r ? 4'd0 : l ? d : e ? (u ? m + 4'd1 : m - 4'd1) : m;
    et = !r && !l && e && (u ? m == 4'd15 : m == 4'd0);
    step(r, e, u, l, d, nx, et);
    m = nx;
  endtask

  initial begin
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd5, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 4'd9, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd10, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b0});
    foreach (tbl[k]) step(tbl[k].r, tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].d, tbl[k].eo, tbl[k].et);
    m = 4'd0;
    for (int k = 0; k < 17; k++) go(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    go(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 3; k++) go(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    go(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    go(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    go(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    go(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    go(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    go(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    go(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    go(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    go(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    go(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    go(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    go(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    go(1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
    for (int k = 0; k < 300; k++)
      go($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
         $urandom_range(0, 11) == 0, 4'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
